// File: rtl/simd_exec_ctrl_pkg.sv
// Shared definitions for the SIMD run-control sequencer: datapath opcodes,
// the sequencer state type and the default timing constants.
package simd_exec_ctrl_pkg;

   // Datapath opcodes held in the INS memory.
   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_MUL = 4'h3,
      OP_MAC = 4'h4
   } simd_opcode_t;

   // Run-control sequencer states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DRAIN,
      S_DONE
   } exec_state_t;

   // Cycles allowed for the R-memory write pipeline to land after the last retire.
   localparam int DEFAULT_DRAIN_CYCLES = 4;
   // Cycles without a retire before the watchdog gives up on a run.
   localparam int DEFAULT_WDOG_CYCLES  = 1024;

endpackage

// File: rtl/simd_exec_ctrl_counter.sv
// exec_counter: clearable up-counter that sticks at all-ones instead of
// wrapping. Used for the retired count, the run cycle count and the watchdog.
module exec_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   // Clear has priority over counting; counting stops at all-ones.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/simd_exec_ctrl.sv
// simd_exec_ctrl: run-control sequencer for the SIMD datapath. Launches a
// program, counts retired instructions, waits for R-memory writes to drain,
// then reports done and the run cycle count. PS writes into A/B/INS are
// blocked while busy and any such attempt is flagged.
// Optional watchdog (wdog_err port) is built when SIMD_EXEC_WDOG_EN is defined.
module simd_exec_ctrl
   import simd_exec_ctrl_pkg::*;
#(
   parameter int INS_ADDR_WIDTH = 11,
   parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
   parameter int CYC_WIDTH      = 32,
   parameter int WDOG_CYCLES    = DEFAULT_WDOG_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [INS_ADDR_WIDTH:0]   ins_count,
   input  logic                      abort,
   input  logic                      hold,
   input  logic                      ps_a_wr_en,
   input  logic                      ps_b_wr_en,
   input  logic                      ps_ins_wr_en,
   output logic                      bram_a_wr_en,
   output logic                      bram_b_wr_en,
   output logic                      bram_ins_wr_en,
   output logic                      dp_in_data_valid,
   output logic                      dp_stall,
   input  logic                      dp_out_data_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic                      wr_conflict,
   output logic [CYC_WIDTH-1:0]      run_cycles
`ifdef SIMD_EXEC_WDOG_EN
   ,
   output logic                      wdog_err
`endif
);

   localparam int         CNT_W      = INS_ADDR_WIDTH + 1;
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   exec_state_t      state_q;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_nx;
   logic [3:0]       drain_q;
   logic             done_q;
   logic             aborted_q;
   logic             wr_conflict_q;
   logic             dp_stall_q;
   logic             start_accept;
   logic             in_run;
   logic             retire;
   logic             last_retire;
   logic             wr_attempt;

   assign busy             = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign in_run           = (state_q == S_RUN);
   assign start_accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign retire           = in_run && dp_out_data_valid;
   assign retired_nx       = retired_q + CNT_W'(1);
   assign last_retire      = retire && (retired_nx == target_q);
   assign wr_attempt       = ps_a_wr_en || ps_b_wr_en || ps_ins_wr_en;

   assign bram_a_wr_en     = ps_a_wr_en   & ~busy;
   assign bram_b_wr_en     = ps_b_wr_en   & ~busy;
   assign bram_ins_wr_en   = ps_ins_wr_en & ~busy;
   assign dp_in_data_valid = (state_q == S_LAUNCH);
   assign dp_stall         = dp_stall_q;
   assign done             = done_q;
   assign aborted          = aborted_q;
   assign wr_conflict      = wr_conflict_q;

   // Instructions retired in the current run.
   exec_counter #(.WIDTH(CNT_W)) u_retired (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_accept),
      .en_i  (retire),
      .cnt_o (retired_q)
   );

   // Cycles spent in LAUNCH, RUN and DRAIN.
   exec_counter #(.WIDTH(CYC_WIDTH)) u_run_cycles (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_accept),
      .en_i  (busy),
      .cnt_o (run_cycles)
   );

`ifdef SIMD_EXEC_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wdog_q;
   logic            wdog_hit;
   logic            wdog_err_q;

   // Cycles in RUN since the last retire; restarts on every retire.
   exec_counter #(.WIDTH(WD_W)) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .clr_i (~in_run | dp_out_data_valid),
      .en_i  (in_run),
      .cnt_o (wdog_q)
   );

   assign wdog_hit = in_run && !dp_out_data_valid && (wdog_q == WD_W'(WDOG_CYCLES - 1));
   assign wdog_err = wdog_err_q;
`endif

   // Sequencer FSM with registered status and stall outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         target_q      <= '0;
         drain_q       <= '0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         wr_conflict_q <= 1'b0;
         dp_stall_q    <= 1'b1;
`ifdef SIMD_EXEC_WDOG_EN
         wdog_err_q    <= 1'b0;
`endif
      end else begin
         if (busy && wr_attempt) begin
            wr_conflict_q <= 1'b1;
         end
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  target_q      <= ins_count;
                  done_q        <= 1'b0;
                  aborted_q     <= 1'b0;
                  wr_conflict_q <= 1'b0;
`ifdef SIMD_EXEC_WDOG_EN
                  wdog_err_q    <= 1'b0;
`endif
                  if (ins_count != '0) begin
                     state_q    <= S_LAUNCH;
                     dp_stall_q <= hold;
                  end else begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               dp_stall_q <= hold;
               drain_q    <= '0;
               if (abort) begin
                  aborted_q <= 1'b1;
                  state_q   <= S_DRAIN;
               end else begin
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               dp_stall_q <= hold;
               drain_q    <= '0;
               if (abort) begin
                  aborted_q <= 1'b1;
                  state_q   <= S_DRAIN;
               end else if (last_retire) begin
                  state_q   <= S_DRAIN;
               end
`ifdef SIMD_EXEC_WDOG_EN
               else if (wdog_hit) begin
                  wdog_err_q <= 1'b1;
                  state_q    <= S_DRAIN;
               end
`endif
            end
            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  dp_stall_q <= 1'b1;
               end else begin
                  drain_q    <= drain_q + 4'd1;
                  dp_stall_q <= hold;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simd_exec_ctrl.sv
// Directed bench for simd_exec_ctrl. A small in-bench datapath model returns
// one out_data_valid per cycle after launch while dp_stall is low.
module tb_simd_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] ins_count;
   logic        abort;
   logic        hold;
   logic        ps_a_wr_en, ps_b_wr_en, ps_ins_wr_en;
   logic        bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en;
   logic        dp_in_data_valid;
   logic        dp_stall;
   logic        dp_out_data_valid;
   logic        busy, done, aborted, wr_conflict;
   logic [31:0] run_cycles;
`ifdef SIMD_EXEC_WDOG_EN
   logic        wdog_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   simd_exec_ctrl #(.WDOG_CYCLES(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .ins_count         (ins_count),
      .abort             (abort),
      .hold              (hold),
      .ps_a_wr_en        (ps_a_wr_en),
      .ps_b_wr_en        (ps_b_wr_en),
      .ps_ins_wr_en      (ps_ins_wr_en),
      .bram_a_wr_en      (bram_a_wr_en),
      .bram_b_wr_en      (bram_b_wr_en),
      .bram_ins_wr_en    (bram_ins_wr_en),
      .dp_in_data_valid  (dp_in_data_valid),
      .dp_stall          (dp_stall),
      .dp_out_data_valid (dp_out_data_valid),
      .busy              (busy),
      .done              (done),
      .aborted           (aborted),
      .wr_conflict       (wr_conflict),
      .run_cycles        (run_cycles)
`ifdef SIMD_EXEC_WDOG_EN
      ,
      .wdog_err          (wdog_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {dp_stall, busy, done, aborted, wr_conflict, dp_in_data_valid}
   function automatic logic [5:0] status();
      return {dp_stall, busy, done, aborted, wr_conflict, dp_in_data_valid};
   endfunction

   task automatic wait_done(input int bound, output int n);
      n = -1;
      for (int i = 0; i <= bound; i++) begin
         if (done) begin
            n = i;
            return;
         end
         tick();
      end
   endtask

   // Runs one program. Cycle 0 drives start; cycle k is observed after k edges.
   task automatic run_prog(input int cnt, input int extra, input int hold_at, input int hold_len,
                           input int abort_after, input int restart_at,
                           output int done_cyc, output int last_pulse, output int idv_cnt,
                           output int stall_cnt, output int first_stall);
      int left, sent, launch_cyc;
      bit abort_done;
      left = cnt + extra; sent = 0; launch_cyc = -1; abort_done = 1'b0;
      done_cyc = -1; last_pulse = -1; idv_cnt = 0; stall_cnt = 0; first_stall = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc > 0) begin
            if (dp_in_data_valid) begin
               idv_cnt++;
               if (launch_cyc < 0) launch_cyc = cyc;
            end
            if (busy && dp_stall) begin
               stall_cnt++;
               if (first_stall < 0) first_stall = cyc;
            end
            if (done) begin
               done_cyc = cyc;
               break;
            end
         end
         start     = (cyc == 0) || (cyc == restart_at);
         ins_count = (cyc == 0) ? 12'(cnt) : 12'd1;
         hold      = (cyc >= hold_at) && (cyc < hold_at + hold_len);
         abort     = 1'b0;
         if (abort_after >= 0 && !abort_done && launch_cyc >= 0 && cyc > launch_cyc && sent == abort_after) begin
            abort      = 1'b1;
            abort_done = 1'b1;
            left       = 0;
         end
         dp_out_data_valid = 1'b0;
         if (launch_cyc >= 0 && cyc > launch_cyc && left > 0 && !dp_stall) begin
            dp_out_data_valid = 1'b1;
            left--;
            sent++;
            if (sent == cnt) last_pulse = cyc;
         end
         tick();
      end
      start = 1'b0; hold = 1'b0; abort = 1'b0; dp_out_data_valid = 1'b0;
      if (done_cyc < 0) begin
         checks++; failures++;
         $display("FAIL run_timeout: done not seen within 100 cycles (count %0d)", cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (status() !== 6'b100000) begin failures++; $display("FAIL reset_status: got %b expected 100000", status()); end
      checks++;
      if (run_cycles !== 32'd0) begin failures++; $display("FAIL reset_run_cycles: got %0d expected 0", run_cycles); end
      rst = 1'b0;
      tick();
      checks++;
      if (status() !== 6'b100000) begin failures++; $display("FAIL idle_status: got %b expected 100000", status()); end
   endtask

   task automatic test_basic();
      int d, lp, idv, sc, fs;
      // five instructions plus one stray retire pulse during DRAIN
      run_prog(5, 1, -1, 0, -1, -1, d, lp, idv, sc, fs);
      checks++;
      if (idv !== 1) begin failures++; $display("FAIL basic_launch_pulses: got %0d expected 1", idv); end
      checks++;
      if (d - lp !== 5) begin failures++; $display("FAIL basic_done_latency: got %0d expected 5", d - lp); end
      checks++;
      if (d !== 11) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 11", d); end
      checks++;
      if (run_cycles !== 32'd10) begin failures++; $display("FAIL basic_run_cycles: got %0d expected 10", run_cycles); end
      checks++;
      if ({aborted, busy, dp_stall} !== 3'b001) begin failures++; $display("FAIL basic_done_flags: got %b expected 001", {aborted, busy, dp_stall}); end
   endtask

   task automatic test_zero_count();
      int d, lp, idv, sc, fs;
      run_prog(0, 0, -1, 0, -1, -1, d, lp, idv, sc, fs);
      checks++;
      if (d !== 1) begin failures++; $display("FAIL zero_done_cycle: got %0d expected 1", d); end
      checks++;
      if (idv !== 0) begin failures++; $display("FAIL zero_launch_pulses: got %0d expected 0", idv); end
      checks++;
      if (run_cycles !== 32'd0) begin failures++; $display("FAIL zero_run_cycles: got %0d expected 0", run_cycles); end
   endtask

   task automatic test_hold();
      int d, lp, idv, sc, fs;
      // hold during cycles 4..13; a second start at cycle 3 must be ignored
      run_prog(5, 0, 4, 10, -1, 3, d, lp, idv, sc, fs);
      checks++;
      if (sc !== 10) begin failures++; $display("FAIL hold_stall_cycles: got %0d expected 10", sc); end
      checks++;
      if (fs !== 5) begin failures++; $display("FAIL hold_stall_first: got %0d expected 5", fs); end
      checks++;
      if (d !== 21) begin failures++; $display("FAIL hold_done_cycle: got %0d expected 21", d); end
      checks++;
      if (run_cycles !== 32'd20) begin failures++; $display("FAIL hold_run_cycles: got %0d expected 20", run_cycles); end
      checks++;
      if (idv !== 1) begin failures++; $display("FAIL hold_launch_pulses: got %0d expected 1", idv); end
   endtask

   task automatic test_wr_gating();
      int n;
      ps_a_wr_en = 1'b1;
      #1;
      checks++;
      if (bram_a_wr_en !== 1'b1) begin failures++; $display("FAIL gate_idle_pass: got %b expected 1", bram_a_wr_en); end
      tick();
      ps_a_wr_en = 1'b0;
      checks++;
      if (wr_conflict !== 1'b0) begin failures++; $display("FAIL gate_idle_conflict: got %b expected 0", wr_conflict); end
      start = 1'b1; ins_count = 12'd2;
      tick();
      start = 1'b0;
      tick();
      ps_a_wr_en = 1'b1; ps_b_wr_en = 1'b1; ps_ins_wr_en = 1'b1;
      #1;
      checks++;
      if ({bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en} !== 3'b000) begin
         failures++; $display("FAIL gate_run_block: got %b expected 000", {bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en});
      end
      dp_out_data_valid = 1'b1;
      tick();
      ps_a_wr_en = 1'b0; ps_b_wr_en = 1'b0; ps_ins_wr_en = 1'b0;
      checks++;
      if (wr_conflict !== 1'b1) begin failures++; $display("FAIL gate_run_conflict: got %b expected 1", wr_conflict); end
      tick();
      dp_out_data_valid = 1'b0;
      wait_done(20, n);
      checks++;
      if (n !== 4) begin failures++; $display("FAIL gate_drain_len: got %0d expected 4", n); end
      checks++;
      if (wr_conflict !== 1'b1) begin failures++; $display("FAIL gate_conflict_sticky: got %b expected 1", wr_conflict); end
      start = 1'b1; ins_count = 12'd1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, wr_conflict} !== 2'b10) begin failures++; $display("FAIL gate_start_clears: got %b expected 10", {busy, wr_conflict}); end
      tick();
      dp_out_data_valid = 1'b1;
      tick();
      dp_out_data_valid = 1'b0;
      wait_done(20, n);
   endtask

   task automatic test_abort();
      int d, lp, idv, sc, fs;
      run_prog(8, 0, -1, 0, 2, -1, d, lp, idv, sc, fs);
      checks++;
      if (d !== 9) begin failures++; $display("FAIL abort_done_cycle: got %0d expected 9", d); end
      checks++;
      if (aborted !== 1'b1) begin failures++; $display("FAIL abort_flag: got %b expected 1", aborted); end
      checks++;
      if (run_cycles !== 32'd8) begin failures++; $display("FAIL abort_run_cycles: got %0d expected 8", run_cycles); end
      run_prog(3, 0, -1, 0, -1, -1, d, lp, idv, sc, fs);
      checks++;
      if (aborted !== 1'b0) begin failures++; $display("FAIL abort_cleared: got %b expected 0", aborted); end
      checks++;
      if (d !== 9) begin failures++; $display("FAIL rerun_done_cycle: got %0d expected 9", d); end
      checks++;
      if (run_cycles !== 32'd8) begin failures++; $display("FAIL rerun_run_cycles: got %0d expected 8", run_cycles); end
   endtask

   task automatic test_start_abort();
      int n;
      start = 1'b1; abort = 1'b1; ins_count = 12'd1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++;
      if ({busy, dp_in_data_valid, aborted} !== 3'b110) begin
         failures++; $display("FAIL start_wins: got %b expected 110", {busy, dp_in_data_valid, aborted});
      end
      tick();
      dp_out_data_valid = 1'b1;
      tick();
      dp_out_data_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done(20, n);
      checks++;
      if (n !== 3) begin failures++; $display("FAIL drain_abort_len: got %0d expected 3", n); end
      checks++;
      if (aborted !== 1'b0) begin failures++; $display("FAIL drain_abort_flag: got %b expected 0", aborted); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({done, aborted, busy} !== 3'b100) begin failures++; $display("FAIL done_abort_ignored: got %b expected 100", {done, aborted, busy}); end
   endtask

`ifdef SIMD_EXEC_WDOG_EN
   task automatic test_wdog();
      int d, lp, idv, sc, fs;
      // no retires at all: launch at cycle 1, 16 RUN, 4 DRAIN, done at 22
      run_prog(3, -3, -1, 0, -1, -1, d, lp, idv, sc, fs);
      checks++;
      if (d !== 22) begin failures++; $display("FAIL wdog_done_cycle: got %0d expected 22", d); end
      checks++;
      if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_err_set: got %b expected 1", wdog_err); end
      run_prog(2, 0, -1, 0, -1, -1, d, lp, idv, sc, fs);
      checks++;
      if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_err_clear: got %b expected 0", wdog_err); end
      checks++;
      if (d !== 8) begin failures++; $display("FAIL wdog_rerun_done: got %0d expected 8", d); end
   endtask
`endif

   task automatic test_rst_midrun();
      int seen;
      start = 1'b1; ins_count = 12'd4;
      tick();
      start = 1'b0;
      tick();
      ps_b_wr_en = 1'b1; dp_out_data_valid = 1'b1;
      tick();
      ps_b_wr_en = 1'b0; dp_out_data_valid = 1'b0;
      checks++;
      if ({busy, wr_conflict} !== 2'b11) begin failures++; $display("FAIL midrun_pre: got %b expected 11", {busy, wr_conflict}); end
      rst = 1'b1;
      tick();
      checks++;
      if (status() !== 6'b100000) begin failures++; $display("FAIL midrun_rst_status: got %b expected 100000", status()); end
      checks++;
      if (run_cycles !== 32'd0) begin failures++; $display("FAIL midrun_rst_cycles: got %0d expected 0", run_cycles); end
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         tick();
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ins_count = '0; abort = 1'b0; hold = 1'b0;
      ps_a_wr_en = 1'b0; ps_b_wr_en = 1'b0; ps_ins_wr_en = 1'b0; dp_out_data_valid = 1'b0;
      test_reset();
      test_basic();
      test_zero_count();
      test_hold();
      test_wr_gating();
      test_abort();
      test_start_abort();
`ifdef SIMD_EXEC_WDOG_EN
      test_wdog();
`endif
      test_rst_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
